// File: rtl/puf_framework_pkg.sv
// Shared constants and state encoding for the PUF response framing path.
package puf_framework_pkg;

    localparam int UART_BITS_DEF = 8;
    localparam logic [7:0] RESPONSE_ID_DEF = 8'b1010_1011;
    localparam logic [7:0] REQUEST_ID_DEF = 8'b0101_1010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_FETCH,
        ST_LATCH,
        ST_DATA,
        ST_CHK,
        ST_FIN,
        ST_ABORT
    } pkt_state_e;

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte tx_enable/tx_busy handshake; byte_done pulses once the UART
// has gone busy and then idle again.
module uart_byte_sender
    import puf_framework_pkg::*;
#(
    parameter int UART_BITS = UART_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [UART_BITS-1:0] byte_in,
    input  logic                 tx_busy,
    output logic [UART_BITS-1:0] tx_data,
    output logic                 tx_enable,
    output logic                 byte_done
);

    localparam logic [1:0] PH_READY   = 2'd0;
    localparam logic [1:0] PH_WAIT_HI = 2'd1;
    localparam logic [1:0] PH_WAIT_LO = 2'd2;

    logic [1:0]           phase_q, phase_d;
    logic [UART_BITS-1:0] data_q, data_d;

    always_comb begin
        phase_d   = phase_q;
        data_d    = data_q;
        tx_enable = 1'b0;
        byte_done = 1'b0;
        tx_data   = data_q;
        unique case (phase_q)
            PH_READY: begin
                if (req && !tx_busy) begin
                    tx_enable = 1'b1;
                    tx_data   = byte_in;
                    data_d    = byte_in;
                    phase_d   = PH_WAIT_HI;
                end
            end
            PH_WAIT_HI: begin
                if (tx_busy) begin
                    phase_d = PH_WAIT_LO;
                end
            end
            PH_WAIT_LO: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                    phase_d   = PH_READY;
                end
            end
            default: phase_d = PH_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= PH_READY;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/response_packetizer.sv
// Frames FIFO response words as header, word count, data (and an XOR
// checksum byte when RESPONSE_PACKETIZER_CHECKSUM_EN is defined).
module response_packetizer
    import puf_framework_pkg::*;
#(
    parameter int WORD_BITS = 32,
    parameter int UART_BITS = UART_BITS_DEF,
    parameter int NUM_WORDS = 1280,
    parameter int COUNT_BYTES = 2,
    parameter logic [UART_BITS-1:0] RESPONSE_ID = RESPONSE_ID_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 fifo_empty,
    input  logic [WORD_BITS-1:0] fifo_dout,
    output logic                 fifo_re,
    output logic [UART_BITS-1:0] tx_data,
    output logic                 tx_enable,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int BPW     = WORD_BITS / UART_BITS;
    localparam int WCW     = $clog2(NUM_WORDS + 1);
    localparam int CFW     = 8 * COUNT_BYTES;
    localparam int IDX_MAX = (BPW > COUNT_BYTES) ? BPW : COUNT_BYTES;
    localparam int IDXW    = $clog2(IDX_MAX) + 1;
    localparam logic [CFW-1:0] CNT_FIELD = CFW'(NUM_WORDS);

    pkt_state_e           state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d, wcnt_inc;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CFW-1:0]       cnt_sh_q, cnt_sh_d;
    logic                 underrun_q, underrun_d;
    logic                 send, byte_done;
    logic [UART_BITS-1:0] byte_cur;
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
    logic [UART_BITS-1:0] chk_q, chk_d;
`endif

    assign wcnt_inc = wcnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        shreg_d    = shreg_q;
        cnt_sh_d   = cnt_sh_q;
        underrun_d = underrun_q;
        send       = 1'b0;
        byte_cur   = '0;
        fifo_re    = 1'b0;
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    idx_d      = '0;
                    wcnt_d     = '0;
                    cnt_sh_d   = CNT_FIELD;
                    underrun_d = 1'b0;
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            ST_HDR: begin
                send     = 1'b1;
                byte_cur = RESPONSE_ID;
                if (byte_done) begin
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                send     = 1'b1;
                byte_cur = UART_BITS'(cnt_sh_q[CFW-1 -: 8]);
                if (byte_done) begin
                    cnt_sh_d = cnt_sh_q << 8;
                    if (idx_q == IDXW'(COUNT_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (fifo_empty) begin
                    state_d = ST_ABORT;
                end else begin
                    fifo_re = 1'b1;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                shreg_d = fifo_dout;
                idx_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                send     = 1'b1;
                byte_cur = shreg_q[WORD_BITS-1 -: UART_BITS];
                if (byte_done) begin
                    shreg_d = shreg_q << UART_BITS;
                    if (idx_q == IDXW'(BPW - 1)) begin
                        idx_d  = '0;
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc == WCW'(NUM_WORDS)) begin
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_FIN;
`endif
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
            ST_CHK: begin
                send     = 1'b1;
                byte_cur = chk_q;
                if (byte_done) begin
                    state_d = ST_FIN;
                end
            end
`endif
            ST_FIN:   state_d = ST_IDLE;
            ST_ABORT: begin
                underrun_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
        // Fold every byte handed to the UART except the checksum itself
        if (tx_enable && state_q != ST_CHK) begin
            chk_d = chk_q ^ tx_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wcnt_q     <= '0;
            shreg_q    <= '0;
            cnt_sh_q   <= '0;
            underrun_q <= 1'b0;
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            shreg_q    <= shreg_d;
            cnt_sh_q   <= cnt_sh_d;
            underrun_q <= underrun_d;
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    uart_byte_sender #(
        .UART_BITS(UART_BITS)
    ) u_sender (
        .clk      (clk),
        .reset    (reset),
        .req      (send),
        .byte_in  (byte_cur),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_enable(tx_enable),
        .byte_done(byte_done)
    );

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done     = (state_q == ST_FIN);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_response_packetizer.sv
// Scoreboard bench for response_packetizer (NUM_WORDS=2) with FIFO and
// UART responder models.
module tb_response_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        fifo_re;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        done;
    logic        underrun;

    logic [31:0] fifoq[$];
    logic [7:0]  expq[$];
    int          busy_len = 3;
    int          bcnt = 0;
    int          re_cnt = 0;
    int          done_cnt = 0;
    int          nbytes = 0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    response_packetizer #(
        .NUM_WORDS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_re   (fifo_re),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    // FIFO model: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (fifo_re) begin
            re_cnt <= re_cnt + 1;
            if (fifoq.size() > 0) fifo_dout <= fifoq.pop_front();
        end
    end

    always @(negedge clk) fifo_empty = (fifoq.size() == 0);

    // UART model: busy for busy_len cycles after each accepted byte
    always @(posedge clk) begin
        if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end else if (tx_enable) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end
    end

    // Monitor: pop the expected byte for every send request
    always @(negedge clk) begin
        logic [7:0] e;
        if (done) done_cnt++;
        if (tx_enable) begin
            nbytes++;
            checks++;
            if (tx_busy) begin
                fails++;
                $display("FAIL enable_while_busy: tx_enable=1 with tx_busy=%0b, required 0", tx_busy);
            end
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_byte: got %02h, required no byte", tx_data);
            end else begin
                e = expq.pop_front();
                if (tx_data !== e) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h, required %02h", tx_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, inout logic [7:0] x);
        for (int i = 3; i >= 0; i--) begin
            logic [7:0] b;
            b = w[i*8 +: 8];
            expq.push_back(b);
            x = x ^ b;
        end
    endtask

    task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0] x;
        x = 8'hAB ^ 8'h00 ^ 8'h02;
        expq.push_back(8'hAB);
        expq.push_back(8'h00);
        expq.push_back(8'h02);
        push_word(w0, x);
        push_word(w1, x);
`ifdef RESPONSE_PACKETIZER_CHECKSUM_EN
        expq.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", nm, max);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int r0;
        int d0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fifo_re", fifo_re, 0);
        chk("rst_tx_enable", tx_enable, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b1;
        @(negedge clk);

        // Normal two-word frame
        fifoq.push_back(32'h12345678);
        fifoq.push_back(32'hCAFEBABE);
        push_frame(32'h12345678, 32'hCAFEBABE);
        @(negedge clk);
        r0 = re_cnt;
        d0 = done_cnt;
        pulse_start();
        chk("hdr_busy_cycle1", busy, 1);
        chk("hdr_enable_cycle1", tx_enable, 1);
        wait_idle("frame1", 2000);
        chk("frame1_done_pulses", done_cnt - d0, 1);
        chk("frame1_underrun", underrun, 0);
        chk("frame1_reads", re_cnt - r0, 2);
        chk("frame1_left", expq.size(), 0);

        // Underrun: one word for a two-word frame
        fifoq.push_back(32'hDEADBEEF);
        expq.push_back(8'hAB);
        expq.push_back(8'h00);
        expq.push_back(8'h02);
        expq.push_back(8'hDE);
        expq.push_back(8'hAD);
        expq.push_back(8'hBE);
        expq.push_back(8'hEF);
        @(negedge clk);
        d0 = done_cnt;
        pulse_start();
        wait_idle("underrun", 2000);
        chk("ur_flag", underrun, 1);
        chk("ur_no_done", done_cnt - d0, 0);
        chk("ur_busy", busy, 0);
        chk("ur_left", expq.size(), 0);
        fifoq.push_back(32'h0F1E2D3C);
        fifoq.push_back(32'h4B5A6978);
        push_frame(32'h0F1E2D3C, 32'h4B5A6978);
        @(negedge clk);
        pulse_start();
        chk("ur_cleared", underrun, 0);
        wait_idle("frame2", 2000);
        chk("frame2_done", done, 0);
        chk("frame2_left", expq.size(), 0);

        // Reset while the third data byte is in flight
        busy_len = 4;
        fifoq.push_back(32'h12345678);
        fifoq.push_back(32'hCAFEBABE);
        expq.push_back(8'hAB);
        expq.push_back(8'h00);
        expq.push_back(8'h02);
        expq.push_back(8'h12);
        expq.push_back(8'h34);
        expq.push_back(8'h56);
        @(negedge clk);
        nbytes = 0;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (nbytes < 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached", nbytes, 6);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_tx_enable", tx_enable, 0);
        chk("mid_tx_data", tx_data, 0);
        chk("mid_fifo_re", fifo_re, 0);
        chk("mid_underrun", underrun, 0);
        reset = 1'b1;
        wait_tx_idle();
        chk("mid_no_done", done_cnt - d0, 0);
        chk("mid_left", expq.size(), 0);
        fifoq.delete();
        fifoq.push_back(32'hA5A5A5A5);
        fifoq.push_back(32'h00FF00FF);
        push_frame(32'hA5A5A5A5, 32'h00FF00FF);
        @(negedge clk);
        pulse_start();
        wait_idle("frame3", 2000);
        chk("frame3_left", expq.size(), 0);

        // Slow UART, repeated start mid-frame, extra word left in FIFO
        busy_len = 50;
        fifoq.push_back(32'h11223344);
        fifoq.push_back(32'h55667788);
        fifoq.push_back(32'h99AABBCC);
        push_frame(32'h11223344, 32'h55667788);
        @(negedge clk);
        r0 = re_cnt;
        d0 = done_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        wait_idle("frame4", 5000);
        chk("frame4_done_pulses", done_cnt - d0, 1);
        chk("frame4_reads", re_cnt - r0, 2);
        chk("frame4_fifo_left", fifoq.size(), 1);
        chk("frame4_fifo_empty", fifo_empty, 0);
        chk("frame4_left", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
